// File: rtl/spi_matrix_receiver.sv
// SPI slave modelling the LED-matrix driver register file (rows plus control registers).
// Optional BYTE_PAIR_EN: accept address and data as two separate 8-bit cs frames.
module spi_matrix_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mosi,
    input  logic        sclk,
    input  logic        cs,
    output logic [63:0] rows,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  last_addr,
    output logic [7:0]  last_data
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   cs_rise;
    logic                   cs_fall;

    logic                   armed;
    logic [4:0]             bit_count;
    // Only the last 12 bits of a frame carry address and data, so the
    // ignored top nibble is never stored.
    logic [11:0]            shift_reg;

    logic                   commit_en;
    logic                   err_en;
    logic [3:0]             commit_addr;
    logic [7:0]             commit_data;

`ifdef BYTE_PAIR_EN
    logic                   pending_valid;
    logic [3:0]             pending_addr;
`endif

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    always_comb begin
        commit_en   = 1'b0;
        err_en      = 1'b0;
        commit_addr = shift_reg[11:8];
        commit_data = shift_reg[7:0];
        if (cs_rise && armed) begin
            if (bit_count >= 5'd16) begin
                commit_en = 1'b1;
            end
`ifdef BYTE_PAIR_EN
            else if (bit_count == 5'd8) begin
                if (pending_valid) begin
                    commit_en   = 1'b1;
                    commit_addr = pending_addr;
                end
            end
`endif
            else begin
                err_en = 1'b1;
            end
        end
    end

`ifdef BYTE_PAIR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_valid <= 1'b0;
            pending_addr  <= '0;
        end else if (cs_rise && armed) begin
            if (bit_count == 5'd8 && !pending_valid) begin
                pending_valid <= 1'b1;
                pending_addr  <= shift_reg[3:0];
            end else begin
                pending_valid <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed        <= 1'b0;
            bit_count    <= '0;
            shift_reg    <= '0;
            rows         <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            last_addr    <= '0;
            last_data    <= '0;
        end else begin
            armed       <= armed | cs_s;
            frame_valid <= commit_en;
            frame_err   <= err_en;

            // An sclk edge landing with cs already high is not shifted.
            if (armed && cs_fall) begin
                bit_count <= '0;
            end else if (armed && sclk_rise && !cs_s) begin
                shift_reg <= {shift_reg[10:0], mosi_s};
                if (bit_count != 5'd31) begin
                    bit_count <= bit_count + 5'd1;
                end
            end

            if (commit_en) begin
                last_addr <= commit_addr;
                last_data <= commit_data;
                for (int unsigned k = 0; k < 8; k++) begin
                    if (commit_addr == 4'(k + 1)) begin
                        rows[8*k +: 8] <= commit_data;
                    end
                end
                case (commit_addr)
                    4'h9:    decode_mode  <= commit_data;
                    4'hA:    intensity    <= commit_data[3:0];
                    4'hB:    scan_limit   <= commit_data[2:0];
                    4'hC:    shutdown_n   <= commit_data[0];
                    4'hF:    display_test <= commit_data[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_matrix_receiver.sv
// Directed bench for spi_matrix_receiver; byte-pair sequences run when BYTE_PAIR_EN is defined.
module tb_spi_matrix_receiver;

    localparam int PH = 5;

    logic        clk;
    logic        reset;
    logic        mosi;
    logic        sclk;
    logic        cs;
    logic [63:0] rows;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n;
    logic        display_test;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  last_addr;
    logic [7:0]  last_data;

    int total;
    int bad;
    int vcount;
    int ecount;
    int overlap;

    spi_matrix_receiver #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .mosi         (mosi),
        .sclk         (sclk),
        .cs           (cs),
        .rows         (rows),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .last_addr    (last_addr),
        .last_data    (last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) vcount++;
        if (frame_err) ecount++;
        if (frame_valid && frame_err) overlap++;
    end

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        int          exp_nv;
        int          exp_ne;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        @(negedge clk);
        cs = 1'b0;
        repeat (PH) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = data[i];
            repeat (PH) @(negedge clk);
            sclk = 1'b1;
            repeat (PH) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (PH) @(negedge clk);
    endtask

    task automatic close_frame(output int nv, output int ne, output int first);
        cs    = 1'b1;
        nv    = 0;
        ne    = 0;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                nv++;
                if (first == 0) first = i;
            end
            if (frame_err) begin
                ne++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic do_frame(input string name, input logic [31:0] data, input int n,
                            input int exp_nv, input int exp_ne);
        int nv, ne, first;
        send_bits(data, n);
        close_frame(nv, ne, first);
        check({name, "_valid"}, 64'(nv), 64'(exp_nv));
        check({name, "_err"}, 64'(ne), 64'(exp_ne));
    endtask

    initial begin
        int nv, ne, first, v0, e0;
        total = 0; bad = 0; vcount = 0; ecount = 0; overlap = 0;
        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;

        vecs[0]  = '{32'h01FF, 16, 1, 0, 4'h1, 8'hFF};
        vecs[1]  = '{32'h0281, 16, 1, 0, 4'h2, 8'h81};
        vecs[2]  = '{32'h03FF, 16, 1, 0, 4'h3, 8'hFF};
        vecs[3]  = '{32'h0481, 16, 1, 0, 4'h4, 8'h81};
        vecs[4]  = '{32'h05FF, 16, 1, 0, 4'h5, 8'hFF};
        vecs[5]  = '{32'h0681, 16, 1, 0, 4'h6, 8'h81};
        vecs[6]  = '{32'h07FF, 16, 1, 0, 4'h7, 8'hFF};
        vecs[7]  = '{32'h0881, 16, 1, 0, 4'h8, 8'h81};
        vecs[8]  = '{32'h30A0A, 20, 1, 0, 4'hA, 8'h0A};
        vecs[9]  = '{32'h0ABC, 12, 0, 1, 4'hA, 8'h0A};
        vecs[10] = '{32'h0955, 16, 1, 0, 4'h9, 8'h55};
        vecs[11] = '{32'h0F01, 16, 1, 0, 4'hF, 8'h01};
        vecs[12] = '{32'h0D33, 16, 1, 0, 4'hD, 8'h33};
        vecs[13] = '{32'h0000, 16, 1, 0, 4'h0, 8'h00};
        vecs[14] = '{32'h5C00, 16, 1, 0, 4'hC, 8'h00};
        vecs[15] = '{32'h0000, 0, 0, 1, 4'hC, 8'h00};
        vecs[16] = '{32'h01FF, 9, 0, 1, 4'hC, 8'h00};
        vecs[17] = '{32'h7B03, 15, 0, 1, 4'hC, 8'h00};
        vecs[18] = '{32'h10B03, 17, 1, 0, 4'hB, 8'h03};
        vecs[19] = '{32'h0BFE, 16, 1, 0, 4'hB, 8'hFE};
        vecs[20] = '{32'h0AF5, 16, 1, 0, 4'hA, 8'hF5};

        repeat (4) @(negedge clk);
        check("reset_rows", rows, 64'h0);
        check("reset_last_addr", 64'(last_addr), 64'h0);
        check("reset_shutdown", 64'(shutdown_n), 64'h0);
        check("reset_valid", 64'(frame_valid), 64'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // First frame: check commit latency of three clocks after cs rises
        send_bits(32'h0C01, 16);
        close_frame(nv, ne, first);
        check("first_valid", 64'(nv), 64'd1);
        check("first_err", 64'(ne), 64'd0);
        check("first_latency", 64'(first), 64'd3);
        check("first_shutdown", 64'(shutdown_n), 64'h1);
        check("first_addr", 64'(last_addr), 64'hC);
        check("first_data", 64'(last_data), 64'h01);

        for (int i = 0; i < 21; i++) begin
            send_bits(vecs[i].frame, vecs[i].nbits);
            close_frame(nv, ne, first);
            check($sformatf("vec%0d_valid", i), 64'(nv), 64'(vecs[i].exp_nv));
            check($sformatf("vec%0d_err", i), 64'(ne), 64'(vecs[i].exp_ne));
            check($sformatf("vec%0d_addr", i), 64'(last_addr), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d_data", i), 64'(last_data), 64'(vecs[i].exp_data));
        end
        check("tbl_rows", rows, 64'h81FF_81FF_81FF_81FF);
        check("tbl_decode", 64'(decode_mode), 64'h55);
        check("tbl_intensity", 64'(intensity), 64'h5);
        check("tbl_scan", 64'(scan_limit), 64'h6);
        check("tbl_shutdown", 64'(shutdown_n), 64'h0);
        check("tbl_test", 64'(display_test), 64'h1);

        // sclk rising in the same clock as cs rising must not shift a bit
        send_bits(32'h0A03, 16);
        mosi = 1'b1;
        sclk = 1'b1;
        close_frame(nv, ne, first);
        sclk = 1'b0;
        check("coinc_valid", 64'(nv), 64'd1);
        check("coinc_addr", 64'(last_addr), 64'hA);
        check("coinc_data", 64'(last_data), 64'h03);
        check("coinc_intensity", 64'(intensity), 64'h3);

        // Reset in the middle of a frame, then resend the whole frame
        send_bits(32'h0B07 >> 7, 9);
        reset = 1'b1;
        #1;
        check("midrst_scan", 64'(scan_limit), 64'h0);
        check("midrst_rows", rows, 64'h0);
        check("midrst_test", 64'(display_test), 64'h0);
        cs = 1'b1;
        repeat (5) @(negedge clk);
        v0 = vcount;
        e0 = ecount;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        do_frame("resend", 32'h0B07, 16, 1, 0);
        check("resend_scan", 64'(scan_limit), 64'h7);
        check("resend_vcount", 64'(vcount - v0), 64'd1);
        check("resend_ecount", 64'(ecount - e0), 64'd0);

        // cs low across reset release is not a frame
        reset = 1'b1;
        cs = 1'b0;
        repeat (3) @(negedge clk);
        v0 = vcount;
        e0 = ecount;
        reset = 1'b0;
        repeat (16) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("csl_vcount", 64'(vcount - v0), 64'd0);
        check("csl_ecount", 64'(ecount - e0), 64'd0);
        do_frame("csl_after", 32'h0C01, 16, 1, 0);
        check("csl_shutdown", 64'(shutdown_n), 64'h1);

`ifdef BYTE_PAIR_EN
        do_frame("bp_set", 32'h0955, 16, 1, 0);
        check("bp_decode55", 64'(decode_mode), 64'h55);
        do_frame("bp_addr9", 32'h09, 8, 0, 0);
        do_frame("bp_data00", 32'h00, 8, 1, 0);
        check("bp_decode0", 64'(decode_mode), 64'h0);
        check("bp_last_addr", 64'(last_addr), 64'h9);
        do_frame("bp_addrF", 32'h0F, 8, 0, 0);
        do_frame("bp_short5", 32'h15, 5, 0, 1);
        do_frame("bp_addr1", 32'h01, 8, 0, 0);
        check("bp_test", 64'(display_test), 64'h0);
        do_frame("bp_data01", 32'h01, 8, 1, 0);
        check("bp_row0", 64'(rows[7:0]), 64'h01);
        do_frame("bp_addrC", 32'h0C, 8, 0, 0);
        do_frame("bp_full", 32'h0C00, 16, 1, 0);
        check("bp_shutdown", 64'(shutdown_n), 64'h0);
        do_frame("bp_newaddr", 32'h00, 8, 0, 0);
`else
        do_frame("byte_err", 32'h0C, 8, 0, 1);
        check("byte_shutdown", 64'(shutdown_n), 64'h1);
`endif

        check("no_overlap", 64'(overlap), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
